// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM states, SPI mode
// encodings and edge-count helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Mode number encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int unsigned last_edge_idx(input int unsigned data_width);
    return 2 * data_width - 1;
  endfunction

endpackage

// File: rtl/ratio_clk.sv
// Power-of-two clock divider: ratio_clk_o toggles every 2^ratio_i enabled
// cycles; dropping en_i clears the counter but holds the output level.
module ratio_clk #(
  parameter int RATIO_GRADE = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   en_i,
  input  logic [RATIO_GRADE-1:0] ratio_i,
  output logic                   ratio_clk_o
);

  localparam int CW = 1 << RATIO_GRADE;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_limit;

  assign w_limit = (ONE << ratio_i) - ONE;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_cnt       <= '0;
      ratio_clk_o <= 1'b0;
    end else if (!en_i) begin
      r_cnt <= '0;
    end else if (r_cnt == w_limit) begin
      r_cnt       <= '0;
      ratio_clk_o <= ~ratio_clk_o;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: divider toggles act as SCLK half-period events that
// step chip-select, SCLK, MOSI shifting and MISO sampling for one word.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RATIO_GRADE = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [DATA_WIDTH-1:0]  tx_data_i,
  input  logic                   cpol_i,
  input  logic                   cpha_i,
  input  logic                   lsb_first_i,
  input  logic [RATIO_GRADE-1:0] ratio_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  rx_data_o,
  output logic                   spi_sck_o,
  output logic                   spi_cs_n_o,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i
);

  localparam int CNT_WIDTH = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_EDGE = CNT_WIDTH'(last_edge_idx(DATA_WIDTH));

  spi_state_e             r_state, w_next;
  logic [DATA_WIDTH-1:0]  r_tx, r_rx;
  logic [CNT_WIDTH-1:0]   r_edge;
  logic [RATIO_GRADE-1:0] r_ratio;
  logic                   r_cpol, r_cpha, r_lsb, r_started, r_div_d;
  logic                   w_div, w_en, w_tick, w_start, w_step, w_xfer_step;
  logic                   w_finish, w_sample, w_drive, w_lead, w_cpha0, w_cpha1;
  logic [1:0]             w_mode;

  ratio_clk #(.RATIO_GRADE(RATIO_GRADE)) u_div (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .en_i        (w_en),
    .ratio_i     (r_ratio),
    .ratio_clk_o (w_div)
  );

  assign w_en        = (r_state != ST_IDLE);
  assign busy_o      = w_en;
  assign w_tick      = w_div ^ r_div_d;
  assign w_start     = (r_state == ST_IDLE) && start_i && !abort_i;
  assign w_step      = w_tick && w_en && !abort_i;
  assign w_xfer_step = w_step && (r_state == ST_XFER);
  assign w_finish    = w_step && (r_state == ST_HOLD);
  assign w_mode      = {r_cpol, r_cpha};
  assign w_cpha0     = (w_mode == SPI_MODE0) || (w_mode == SPI_MODE2);
  assign w_cpha1     = (w_mode == SPI_MODE1) || (w_mode == SPI_MODE3);
  assign w_lead      = ~r_edge[0];
  assign w_sample    = w_xfer_step && (w_lead ? w_cpha0 : w_cpha1);
  // No drive after the final trailing edge in cpha=0: the last bit must stay put
  assign w_drive     = w_xfer_step && (w_lead ? w_cpha1 : (w_cpha0 && (r_edge != LAST_EDGE)));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
      r_div_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div_d <= w_div;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start_i) w_next = ST_SETUP;
        ST_SETUP: if (w_tick) w_next = ST_XFER;
        ST_XFER:  if (w_tick && (r_edge == LAST_EDGE)) w_next = ST_HOLD;
        ST_HOLD:  if (w_tick) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      done_o     <= 1'b0;
      rx_data_o  <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_edge     <= '0;
      r_ratio    <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        spi_cs_n_o <= 1'b1;
        spi_sck_o  <= r_started ? r_cpol : cpol_i;
      end else if (w_start) begin
        r_cpol     <= cpol_i;
        r_cpha     <= cpha_i;
        r_lsb      <= lsb_first_i;
        r_ratio    <= ratio_i;
        r_started  <= 1'b1;
        spi_cs_n_o <= 1'b0;
        spi_sck_o  <= cpol_i;
        if (cpha_i) begin
          r_tx <= tx_data_i;
        end else begin
          r_tx       <= lsb_first_i ? (tx_data_i >> 1) : (tx_data_i << 1);
          spi_mosi_o <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
        end
      end else begin
        if ((r_state == ST_IDLE) && !r_started) spi_sck_o <= cpol_i;
        if (w_step && (r_state == ST_SETUP)) r_edge <= '0;
        if (w_xfer_step) begin
          spi_sck_o <= ~spi_sck_o;
          r_edge    <= r_edge + CNT_WIDTH'(1);
        end
        if (w_sample) begin
          r_rx <= r_lsb ? {spi_miso_i, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], spi_miso_i};
        end
        if (w_drive) begin
          spi_mosi_o <= r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
          r_tx       <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
        end
        if (w_finish) begin
          spi_cs_n_o <= 1'b1;
          rx_data_o  <= r_rx;
          done_o     <= 1'b1;
        end
      end
    end
  end

endmodule
